mult_calc: RTL
==============

MULT_CALC -- requirements
Module: mult_calc

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 32-bit operands and 32-bit result.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_MULT  input  1  start pulse; sampled on rising edge of clock.
REQ-005 data_operandA  input  32  multiplicand, two's complement; sampled only on a start edge.
REQ-006 data_operandB  input  32  multiplier, two's complement; sampled only on a start edge.
REQ-007 data_result  output  32  low 32 bits of the signed 64-bit product.
REQ-008 data_exception  output  1  signed overflow flag for the current data_result.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking data_result/data_exception valid.

Function
REQ-010 The block SHALL be a sequential modified-Booth radix-4 multiplier, retiring 2 multiplier bits per cycle, 16 steps per product.
REQ-011 The block SHALL have states IDLE, RUN and DONE.
REQ-012 Start edge: ctrl_MULT=1 on a rising edge in any state SHALL latch both operands, clear the 64-bit partial product, set step counter to 0 and enter RUN.
REQ-013 In RUN, each edge SHALL perform one Booth step using multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1]=0), selecting 0, +A, +2A, -A or -2A.
REQ-014 The selected addend SHALL be sign-extended to 34 bits and shifted left by 2i before accumulation; 2A is formed by a 1-bit left shift and -A by two's complement.
REQ-015 The step counter SHALL be 4 bits, 0..15, and SHALL increment once per RUN edge.
REQ-016 On the edge performing step 15, the block SHALL enter DONE, load data_result with product[31:0], and set data_resultRDY=1.
REQ-017 On that same edge, data_exception SHALL be set to 1 iff product[63:31] are not all equal, i.e. the product does not fit in signed 32 bits; otherwise it SHALL be 0.
REQ-018 Latency: with the start edge as E0, data_resultRDY SHALL be high only between edges E16 and E17.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE with data_resultRDY=0.
REQ-020 data_result and data_exception SHALL hold their last values in IDLE and RUN until the next DONE.
REQ-021 Restart: ctrl_MULT=1 during RUN or DONE SHALL abandon the current product without asserting data_resultRDY for it, and SHALL restart per REQ-012.
REQ-022 Operand changes on data_operandA/B outside a start edge SHALL have no effect.
REQ-023 The most negative value 0x80000000 SHALL be handled with 34-bit internal sign extension, so that -A and -2A are exact.

Reset
REQ-024 While reset=1, the block SHALL immediately force state IDLE, counter 0, partial product 0, data_result=0, data_exception=0 and data_resultRDY=0, regardless of clock.
REQ-025 Reset during RUN SHALL discard the operation; no data_resultRDY pulse SHALL follow.
REQ-026 After reset is released, the block SHALL ignore clock edges until the next ctrl_MULT start.

Verification
REQ-027 A=3, B=4, pulse ctrl_MULT at E0 -> data_resultRDY=1 only in the cycle after E16, data_result=0x0000000C, data_exception=0.
REQ-028 A=0xFFFFFFF9 (-7), B=6 -> data_result=0xFFFFFFD6 (-42), data_exception=0; A=0x80000000, B=1 -> 0x80000000, data_exception=0.
REQ-029 Overflow cases, each with data_exception=1:
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE
- A=0x00010000, B=0x00010000 -> data_result=0x00000000
- A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000
REQ-030 Start A=5, B=5, then at E8 start A=2, B=3 -> no pulse at E16; single pulse after E8+16 with data_result=6.
REQ-031 Start A=9, B=9, assert reset asynchronously mid-cycle at E5+half-period -> outputs 0 immediately; no data_resultRDY pulse within the following 20 cycles.
REQ-032 Back-to-back: start at E0, then start again at E17 -> two pulses, after E16 and after E33; results held between the pulses.

Source files
------------

// File: rtl/mult_calc.sv
// rtl/mult_calc.sv - sequential radix-4 Booth 32x32 signed multiplier, 16 steps per product
module mult_calc (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] prod;
    logic [3:0]  step;

    logic [5:0]  shamt;
    logic [32:0] b_ext;
    logic [2:0]  triple;
    logic [33:0] a_ext;
    logic [33:0] addend;
    logic [63:0] addend_wide;
    logic [63:0] prod_next;
    logic [32:0] prod_hi;
    logic        overflow;
    logic        last_step;

    // Step i consumes multiplier bits {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0.
    assign shamt  = {1'b0, step, 1'b0};
    assign b_ext  = {op_b, 1'b0};
    assign triple = b_ext[shamt +: 3];

    // 34 bits keep -A and -2A exact even for A = 0x80000000.
    assign a_ext  = {{2{op_a[31]}}, op_a};

    always_comb begin
        addend = '0;
        case (triple)
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_ext << 1;
            3'b100:         addend = -(a_ext << 1);
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
    end

    assign addend_wide = {{30{addend[33]}}, addend} << shamt;
    assign prod_next   = prod + addend_wide;

    // The product fits in signed 32 bits only when bits 63..31 are all copies of the sign.
    assign prod_hi   = prod_next[63:31];
    assign overflow  = ~((&prod_hi) | ~(|prod_hi));
    assign last_step = (state == RUN) && (step == 4'd15) && !ctrl_MULT;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     state_next = (step == 4'd15) ? DONE : RUN;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a           <= '0;
            op_b           <= '0;
            prod           <= '0;
            step           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_MULT) begin
            // A start in any state abandons whatever was in flight.
            op_a           <= data_operandA;
            op_b           <= data_operandB;
            prod           <= '0;
            step           <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == RUN) begin
                prod <= prod_next;
                step <= step + 4'd1;
            end
            if (last_step) begin
                data_result    <= prod_next[31:0];
                data_exception <= overflow;
                data_resultRDY <= 1'b1;
            end
        end
    end

endmodule
